// File: rtl/mips_sc_core.sv
// Single-cycle MIPS-I subset core: PC, 32x32 register file, ALU, decoder and
// load/store lane alignment; one instruction retires every rising clk.
module mips_sc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_din,
  output logic [3:0]  dmem_be,
  output logic        dmem_wren,
  input  logic [31:0] dmem_dout
);

  logic [31:0] pc, next_pc, pc_plus4, branch_target, jump_target;
  logic [31:0] regs [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, sext_imm, zext_imm;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        wr_en, is_store;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign op       = imem_dout[31:26];
  assign rs       = imem_dout[25:21];
  assign rt       = imem_dout[20:16];
  assign rd       = imem_dout[15:11];
  assign shamt    = imem_dout[10:6];
  assign funct    = imem_dout[5:0];
  assign sext_imm = {{16{imem_dout[15]}}, imem_dout[15:0]};
  assign zext_imm = {16'd0, imem_dout[15:0]};

  assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + (sext_imm << 2);
  assign jump_target   = {pc_plus4[31:28], imem_dout[25:0], 2'b00};

  assign imem_addr = pc;
  assign dmem_addr = rs_val + sext_imm;
  assign load_byte = dmem_dout[{dmem_addr[1:0], 3'b000} +: 8];
  assign load_half = dmem_addr[1] ? dmem_dout[31:16] : dmem_dout[15:0];
  // No store may reach the RAM while the core is held in reset.
  assign dmem_wren = is_store & rst;

  always_comb begin
    next_pc  = pc_plus4;
    wr_en    = 1'b0;
    wr_addr  = rd;
    wr_data  = 32'd0;
    is_store = 1'b0;
    dmem_be  = 4'b0000;
    dmem_din = rt_val;
    case (op)
      6'h00: begin
        wr_en = 1'b1;
        case (funct)
          6'h00: wr_data = rt_val << shamt;
          6'h02: wr_data = rt_val >> shamt;
          6'h03: wr_data = $signed(rt_val) >>> shamt;
          6'h04: wr_data = rt_val << rs_val[4:0];
          6'h06: wr_data = rt_val >> rs_val[4:0];
          6'h07: wr_data = $signed(rt_val) >>> rs_val[4:0];
          6'h08: begin wr_en = 1'b0; next_pc = rs_val; end
          6'h09: begin wr_data = pc_plus4; next_pc = rs_val; end
          6'h20, 6'h21: wr_data = rs_val + rt_val;
          6'h22, 6'h23: wr_data = rs_val - rt_val;
          6'h24: wr_data = rs_val & rt_val;
          6'h25: wr_data = rs_val | rt_val;
          6'h26: wr_data = rs_val ^ rt_val;
          6'h27: wr_data = ~(rs_val | rt_val);
          6'h2a: wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2b: wr_data = {31'd0, rs_val < rt_val};
          default: wr_en = 1'b0;
        endcase
      end
      6'h02: next_pc = jump_target;
      6'h03: begin next_pc = jump_target; wr_en = 1'b1; wr_addr = 5'd31; wr_data = pc_plus4; end
      6'h04: if (rs_val == rt_val) next_pc = branch_target;
      6'h05: if (rs_val != rt_val) next_pc = branch_target;
      6'h06: if (rs_val[31] || rs_val == 32'd0) next_pc = branch_target;
      6'h07: if (!rs_val[31] && rs_val != 32'd0) next_pc = branch_target;
      6'h08, 6'h09: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val + sext_imm; end
      6'h0a: begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'd0, $signed(rs_val) < $signed(sext_imm)}; end
      6'h0b: begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'd0, rs_val < sext_imm}; end
      6'h0c: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val & zext_imm; end
      6'h0d: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val | zext_imm; end
      6'h0e: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val ^ zext_imm; end
      6'h0f: begin wr_en = 1'b1; wr_addr = rt; wr_data = {imem_dout[15:0], 16'd0}; end
      6'h20: begin wr_en = 1'b1; wr_addr = rt; wr_data = {{24{load_byte[7]}}, load_byte}; end
      6'h21: begin wr_en = 1'b1; wr_addr = rt; wr_data = {{16{load_half[15]}}, load_half}; end
      6'h23: begin wr_en = 1'b1; wr_addr = rt; wr_data = dmem_dout; end
      6'h24: begin wr_en = 1'b1; wr_addr = rt; wr_data = {24'd0, load_byte}; end
      6'h25: begin wr_en = 1'b1; wr_addr = rt; wr_data = {16'd0, load_half}; end
      6'h28: begin is_store = 1'b1; dmem_be = 4'b0001 << dmem_addr[1:0]; dmem_din = {4{rt_val[7:0]}}; end
      6'h29: begin is_store = 1'b1; dmem_be = dmem_addr[1] ? 4'b1100 : 4'b0011; dmem_din = {2{rt_val[15:0]}}; end
      6'h2b: begin is_store = 1'b1; dmem_be = 4'b1111; end
      default: ;
    endcase
  end

  // PC and register file; $0 is never written so it always reads back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_sc_core.sv
// Runs a small directed program against instruction/data memory models and
// compares the per-cycle fetch address and store bus with a hand-built trace.
module tb_mips_sc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr, imem_dout, dmem_addr, dmem_din, dmem_dout;
  logic [3:0]  dmem_be;
  logic        dmem_wren;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        wren;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] din;
  } vec_t;

  vec_t vecs[$];

  mips_sc_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_dout (imem_dout),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_be   (dmem_be),
    .dmem_wren (dmem_wren),
    .dmem_dout (dmem_dout)
  );

  always #50 clk = ~clk;

  assign imem_dout = imem[imem_addr[9:2]];
  assign dmem_dout = dmem[dmem_addr[9:2]];

  always @(posedge clk) begin
    if (dmem_wren)
      for (int b = 0; b < 4; b++)
        if (dmem_be[b]) dmem[dmem_addr[9:2]][8*b +: 8] <= dmem_din[8*b +: 8];
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input logic [31:0] pc, input logic wren, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] din);
    vec_t v;
    v.pc = pc; v.wren = wren; v.be = be; v.addr = addr; v.din = din;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] instr);
    imem[pc[9:2]] = instr;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin imem[i] = 32'd0; dmem[i] = 32'd0; end

    apply_stimulus(32'h00, 32'h3401_1234); // ori   $1,$0,0x1234
    apply_stimulus(32'h04, 32'h3C02_ABCD); // lui   $2,0xABCD
    apply_stimulus(32'h08, 32'h0022_1821); // addu  $3,$1,$2
    apply_stimulus(32'h0C, 32'hAC03_0000); // sw    $3,0($0)
    apply_stimulus(32'h10, 32'h8004_0000); // lb    $4,0($0)
    apply_stimulus(32'h14, 32'h9005_0003); // lbu   $5,3($0)
    apply_stimulus(32'h18, 32'hA001_0002); // sb    $1,2($0)
    apply_stimulus(32'h1C, 32'h8C09_0000); // lw    $9,0($0)
    apply_stimulus(32'h20, 32'h1021_0002); // beq   $1,$1,+2
    apply_stimulus(32'h24, 32'hAC01_0100); // skipped
    apply_stimulus(32'h28, 32'hAC01_0100); // skipped
    apply_stimulus(32'h2C, 32'h1421_0005); // bne   $1,$1,+5 (not taken)
    apply_stimulus(32'h30, 32'h0C00_0010); // jal   0x40
    apply_stimulus(32'h40, 32'hAC04_0004); // sw    $4,4($0)
    apply_stimulus(32'h44, 32'hAC05_0008); // sw    $5,8($0)
    apply_stimulus(32'h48, 32'hAC09_000C); // sw    $9,12($0)
    apply_stimulus(32'h4C, 32'hAC1F_0010); // sw    $31,16($0)
    apply_stimulus(32'h50, 32'h0022_0021); // addu  $0,$1,$2
    apply_stimulus(32'h54, 32'hAC00_0014); // sw    $0,20($0)
    apply_stimulus(32'h58, 32'h2407_FFFF); // addiu $7,$0,-1
    apply_stimulus(32'h5C, 32'h2408_0001); // addiu $8,$0,1
    apply_stimulus(32'h60, 32'h00E8_302A); // slt   $6,$7,$8
    apply_stimulus(32'h64, 32'hAC06_0018); // sw    $6,24($0)
    apply_stimulus(32'h68, 32'h00E8_302B); // sltu  $6,$7,$8
    apply_stimulus(32'h6C, 32'hAC06_001C); // sw    $6,28($0)
    apply_stimulus(32'h70, 32'h3C0A_8000); // lui   $10,0x8000
    apply_stimulus(32'h74, 32'h000A_5903); // sra   $11,$10,4
    apply_stimulus(32'h78, 32'hAC0B_0020); // sw    $11,32($0)
    apply_stimulus(32'h7C, 32'hA407_0006); // sh    $7,6($0)
    apply_stimulus(32'h80, 32'h840C_0006); // lh    $12,6($0)
    apply_stimulus(32'h84, 32'h940D_0006); // lhu   $13,6($0)
    apply_stimulus(32'h88, 32'hAC0C_0024); // sw    $12,36($0)
    apply_stimulus(32'h8C, 32'hAC0D_0028); // sw    $13,40($0)
    apply_stimulus(32'h90, 32'hFC01_FFFF); // unknown opcode
    apply_stimulus(32'h94, 32'hAC01_002C); // sw    $1,44($0)
    apply_stimulus(32'h98, 32'h0800_0026); // j     0x98

    add_vec(32'h00, 0, 4'h0, 0, 0);
    add_vec(32'h04, 0, 4'h0, 0, 0);
    add_vec(32'h08, 0, 4'h0, 0, 0);
    add_vec(32'h0C, 1, 4'hF, 32'h00, 32'hABCD_1234);
    add_vec(32'h10, 0, 4'h0, 0, 0);
    add_vec(32'h14, 0, 4'h0, 0, 0);
    add_vec(32'h18, 1, 4'h4, 32'h02, 32'h3434_3434);
    add_vec(32'h1C, 0, 4'h0, 0, 0);
    add_vec(32'h20, 0, 4'h0, 0, 0);
    add_vec(32'h2C, 0, 4'h0, 0, 0);
    add_vec(32'h30, 0, 4'h0, 0, 0);
    add_vec(32'h40, 1, 4'hF, 32'h04, 32'h0000_0034);
    add_vec(32'h44, 1, 4'hF, 32'h08, 32'h0000_00AB);
    add_vec(32'h48, 1, 4'hF, 32'h0C, 32'hAB34_1234);
    add_vec(32'h4C, 1, 4'hF, 32'h10, 32'h0000_0034);
    add_vec(32'h50, 0, 4'h0, 0, 0);
    add_vec(32'h54, 1, 4'hF, 32'h14, 32'h0000_0000);
    add_vec(32'h58, 0, 4'h0, 0, 0);
    add_vec(32'h5C, 0, 4'h0, 0, 0);
    add_vec(32'h60, 0, 4'h0, 0, 0);
    add_vec(32'h64, 1, 4'hF, 32'h18, 32'h0000_0001);
    add_vec(32'h68, 0, 4'h0, 0, 0);
    add_vec(32'h6C, 1, 4'hF, 32'h1C, 32'h0000_0000);
    add_vec(32'h70, 0, 4'h0, 0, 0);
    add_vec(32'h74, 0, 4'h0, 0, 0);
    add_vec(32'h78, 1, 4'hF, 32'h20, 32'hF800_0000);
    add_vec(32'h7C, 1, 4'hC, 32'h06, 32'hFFFF_FFFF);
    add_vec(32'h80, 0, 4'h0, 0, 0);
    add_vec(32'h84, 0, 4'h0, 0, 0);
    add_vec(32'h88, 1, 4'hF, 32'h24, 32'hFFFF_FFFF);
    add_vec(32'h8C, 1, 4'hF, 32'h28, 32'h0000_FFFF);
    add_vec(32'h90, 0, 4'h0, 0, 0);
    add_vec(32'h94, 1, 4'hF, 32'h2C, 32'h0000_1234);
    add_vec(32'h98, 0, 4'h0, 0, 0);
    add_vec(32'h98, 0, 4'h0, 0, 0);

    #500;
    check_output("reset_wren", {31'd0, dmem_wren}, 32'd0);
    check_output("reset_pc", imem_addr, 32'h0);
    rst = 1'b1;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      check_output($sformatf("pc[%0d]", i), imem_addr, vecs[i].pc);
      check_output($sformatf("wren[%0d]", i), {31'd0, dmem_wren}, {31'd0, vecs[i].wren});
      check_output($sformatf("be[%0d]", i), {28'd0, dmem_be}, {28'd0, vecs[i].be});
      if (vecs[i].wren) begin
        check_output($sformatf("addr[%0d]", i), dmem_addr, vecs[i].addr);
        check_output($sformatf("din[%0d]", i), dmem_din, vecs[i].din);
      end
      @(negedge clk);
    end

    check_output("ram_word0", dmem[0], 32'hAB34_1234);
    check_output("ram_word1", dmem[1], 32'hFFFF_0034);
    check_output("ram_word9", dmem[9], 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a cycle takes effect immediately.
    #20 rst = 1'b0;
    #1;
    check_output("midreset_pc", imem_addr, 32'h0);
    check_output("midreset_reg31", dut.regs[31], 32'h0);
    check_output("midreset_reg1", dut.regs[1], 32'h0);
    @(negedge clk);
    check_output("held_reset_pc", imem_addr, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rerun_pc", imem_addr, 32'h0C);
    check_output("rerun_wren", {31'd0, dmem_wren}, 32'd1);
    check_output("rerun_din", dmem_din, 32'hABCD_1234);

    // Reset landing on a store must suppress its RAM write.
    #10 rst = 1'b0;
    #1;
    check_output("store_reset_wren", {31'd0, dmem_wren}, 32'd0);
    @(negedge clk);
    check_output("store_suppressed", dmem[0], 32'hAB34_1234);
    rst = 1'b1;
    #1;
    check_output("release_pc", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
